// File: rtl/bias_stream_ctrl.sv
// rtl/bias_stream_ctrl.sv - bias ROM sequencer streaming MEM_SIZE words x REPEAT passes into an ap_fifo
//
// Ports:
//   ap_clk, ap_rst        clock (rising edge), synchronous active-high reset
//   ap_start              start request, only looked at while idle
//   ap_done, ap_idle      one-cycle completion pulse, idle level
//   bias_V_address0/ce0   ROM address and read enable
//   bias_V_q0             ROM data, valid the cycle after ce0
//   output_V_din/write    stream data and write strobe
//   output_V_full_n       downstream has room
//
// Optional macro BIAS_STREAM_CTRL_CONTINUOUS_EN: when defined, REPEAT=0 streams
// forever (no ap_done, only ap_rst stops it). When undefined, REPEAT=0 acts as 1.
module bias_stream_ctrl #(
    parameter int MEM_SIZE   = 32,
    parameter int DATA_WIDTH = 16,
    parameter int REPEAT     = 1,
    parameter int ADDR_W     = $clog2(MEM_SIZE)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic [ADDR_W-1:0]     bias_V_address0,
    output logic                  bias_V_ce0,
    input  logic [DATA_WIDTH-1:0] bias_V_q0,
    output logic [DATA_WIDTH-1:0] output_V_din,
    input  logic                  output_V_full_n,
    output logic                  output_V_write
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

`ifdef BIAS_STREAM_CTRL_CONTINUOUS_EN
    localparam bit CONTINUOUS = (REPEAT == 0);
`else
    localparam bit CONTINUOUS = 1'b0;
`endif
    localparam int              REPEAT_EFF = (REPEAT == 0) ? 1 : REPEAT;
    localparam logic [31:0]     TOTAL      = 32'(MEM_SIZE * REPEAT_EFF);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

    state_t                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [15:0]           pass_q;
    logic [31:0]           issued_q;
    logic [31:0]           written_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    logic       push;
    logic       pop;
    logic       issue;
    logic [1:0] count_d;
    logic [2:0] occ_proj;

    always_comb begin
        push     = inflight_q;
        pop      = (count_q != 2'd0) && output_V_full_n;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        // Room must cover the word already in flight; a pop this cycle frees a slot,
        // which is what keeps one read per cycle going while the consumer keeps up.
        occ_proj = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue    = (state_q == S_RUN) && (CONTINUOUS || (issued_q < TOTAL))
                   && (occ_proj < 3'd2);
    end

    assign bias_V_ce0      = issue;
    assign bias_V_address0 = addr_q;
    assign output_V_write  = pop;
    assign output_V_din    = buf_q[rd_ptr_q];
    assign ap_idle         = (state_q == S_IDLE);
    assign ap_done         = (state_q == S_DONE);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            issued_q   <= '0;
            written_q  <= '0;
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            count_q    <= count_d;
            if (push) begin
                buf_q[wr_ptr_q] <= bias_V_q0;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q  <= ~rd_ptr_q;
                written_q <= written_q + 32'd1;
            end
            if (issue) begin
                issued_q <= issued_q + 32'd1;
                if (addr_q == LAST_ADDR) begin
                    addr_q <= '0;
                    pass_q <= pass_q + 16'd1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        state_q   <= S_RUN;
                        addr_q    <= '0;
                        pass_q    <= '0;
                        issued_q  <= '0;
                        written_q <= '0;
                    end
                end
                S_RUN: begin
                    if (!CONTINUOUS && issue && (issued_q + 32'd1 == TOTAL))
                        state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Leave on the edge of the final write so ap_done follows it directly.
                    if (pop && (written_q + 32'd1 == TOTAL))
                        state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
